// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back cache array, 64 lines x 4 words, combinational lookup
module data_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        store,
  input  logic        edit,
  input  logic        invalid,
  input  logic [31:0] din,
  output logic        hit,
  output logic [31:0] dout,
  output logic        valid,
  output logic        dirty,
  output logic [21:0] tag
);
  logic [31:0] data_q [64][4];
  logic [21:0] tag_q [64];
  logic [63:0] valid_q;
  logic [63:0] dirty_q;
  logic [5:0]  idx;
  logic [1:0]  off;
  logic [21:0] atag;
  logic        valid_d;
  logic        dirty_d;
  logic [21:0] tag_d;
  logic        wr_d;
  assign idx   = addr[9:4];
  assign off   = addr[3:2];
  assign atag  = addr[31:10];
  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign dout  = data_q[idx][off];
  assign hit   = valid && (tag == atag);
  // next line status for the indexed line; invalid beats store beats edit
  always_comb begin
    valid_d = invalid ? 1'b0 : store ? 1'b1 : valid;
    dirty_d = (invalid || store) ? 1'b0 : (edit && hit) ? 1'b1 : dirty;
    tag_d   = (!invalid && store) ? atag : tag;
    wr_d    = !invalid && (store || (edit && hit));
  end
  // array update; reset wipes every line including data
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < 64; i++) begin
        tag_q[i] <= '0;
        for (int j = 0; j < 4; j++) data_q[i][j] <= '0;
      end
    end else begin
      valid_q[idx] <= valid_d;
      dirty_q[idx] <= dirty_d;
      tag_q[idx]   <= tag_d;
      if (wr_d) data_q[idx][off] <= din;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed self-checking bench for data_cache
module tb_data_cache;
  logic        clk = 1'b0;
  logic        rst, store, edit, invalid;
  logic [31:0] addr, din, dout;
  logic        hit, valid, dirty;
  logic [21:0] tag;
  int n_checks = 0;
  int n_fail = 0;
  data_cache dut (
    .clk(clk), .rst(rst), .addr(addr), .store(store), .edit(edit),
    .invalid(invalid), .din(din), .hit(hit), .dout(dout), .valid(valid),
    .dirty(dirty), .tag(tag)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic look(input logic [31:0] a);
    addr = a;
    #1;
  endtask
  task automatic status(input string name, input logic h, input logic v, input logic d, input logic [21:0] t, input logic [31:0] q);
    check({name, ".hit"}, {31'd0, hit}, {31'd0, h});
    check({name, ".valid"}, {31'd0, valid}, {31'd0, v});
    check({name, ".dirty"}, {31'd0, dirty}, {31'd0, d});
    check({name, ".tag"}, {10'd0, tag}, {10'd0, t});
    check({name, ".dout"}, dout, q);
  endtask
  initial begin
    rst = 1'b1; store = 1'b0; edit = 1'b0; invalid = 1'b0; addr = '0; din = '0;
    tick();
    tick();
    rst = 1'b0;
    look(32'h1234);
    status("reset", 1'b0, 1'b0, 1'b0, 22'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      addr = 32'h1230 + 32'(4 * i);
      din = 32'hA0 + 32'(i);
      store = 1'b1;
      tick();
    end
    store = 1'b0;
    look(32'h1238);
    status("fill", 1'b1, 1'b1, 1'b0, 22'h4, 32'hA2);
    look(32'h123C);
    check("fill.w3", dout, 32'hA3);
    look(32'h1231);
    check("fill.byteoff", dout, 32'hA0);
    addr = 32'h1234; din = 32'hDEAD_BEEF; edit = 1'b1;
    #1;
    check("edit.noforward", dout, 32'hA1);
    tick();
    edit = 1'b0;
    status("edit", 1'b1, 1'b1, 1'b1, 22'h4, 32'hDEAD_BEEF);
    look(32'h1230);
    check("edit.w0", dout, 32'hA0);
    look(32'h1630);
    status("conflict", 1'b0, 1'b1, 1'b1, 22'h4, 32'hA0);
    din = 32'h1234_5678; edit = 1'b1;
    tick();
    edit = 1'b0;
    check("missedit.w0", dout, 32'hA0);
    look(32'h1234);
    status("missedit", 1'b1, 1'b1, 1'b1, 22'h4, 32'hDEAD_BEEF);
    addr = 32'h1630; din = 32'h55; store = 1'b1; edit = 1'b1;
    tick();
    store = 1'b0; edit = 1'b0;
    status("prio", 1'b1, 1'b1, 1'b0, 22'h5, 32'h55);
    look(32'h1634);
    check("prio.oldword", dout, 32'hDEAD_BEEF);
    addr = 32'h1630; din = 32'h99; invalid = 1'b1; store = 1'b1;
    tick();
    invalid = 1'b0; store = 1'b0;
    status("inval", 1'b0, 1'b0, 1'b0, 22'h5, 32'h55);
    tick();
    status("hold", 1'b0, 1'b0, 1'b0, 22'h5, 32'h55);
    addr = 32'h1238; din = 32'h77; store = 1'b1;
    tick();
    store = 1'b0;
    status("refill", 1'b1, 1'b1, 1'b0, 22'h4, 32'h77);
    rst = 1'b1; edit = 1'b1; din = 32'hFF;
    tick();
    rst = 1'b0; edit = 1'b0;
    status("midrst", 1'b0, 1'b0, 1'b0, 22'h0, 32'h0);
    look(32'h1634);
    check("midrst.w1", dout, 32'h0);
    look(32'h0);
    status("midrst.line0", 1'b0, 1'b0, 1'b0, 22'h0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back cache storage array used by the memory control unit in front of the data RAM.
- Provides:
  - combinational lookup for hit, read data and line status;
  - synchronous single-word writes for line fill (store), CPU write hit (edit) and line invalidation (invalid).
- Contains no FSM and no memory interface. The controller sequences refills and write-backs using the tag, valid and dirty outputs.

Parameters:
- None. Geometry is fixed:
  - 32-bit byte address; 64 lines of 4 x 32-bit words (16-byte lines, 1 KiB data).
  - tag = addr[31:10] (22 bits), index = addr[9:4] (6 bits), word offset = addr[3:2].
  - addr[1:0] is ignored.

Ports:
- clk      input   1   clock; all state updates on rising edge.
- rst      input   1   reset.
- addr     input   32  byte address; selects line (index) and word (offset) for both lookup and write.
- store    input   1   fill write: din -> word, line tag <= addr tag, valid <= 1, dirty <= 0.
- edit     input   1   CPU write: din -> word and dirty <= 1, only if hit.
- invalid  input   1   invalidate indexed line: valid <= 0, dirty <= 0.
- din      input   32  write data.
- hit      output  1   valid[index] AND tag[index] == addr[31:10].
- dout     output  32  data[index][addr[3:2]], regardless of hit.
- valid    output  1   valid bit of indexed line.
- dirty    output  1   dirty bit of indexed line.
- tag      output  22  stored tag of indexed line; used by the controller to form the write-back address.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset: on a clk edge with rst=1, every line gets valid=0, dirty=0, tag=0 and all data words=0. Write commands in the same cycle are ignored.
- Outputs after reset, for any addr: hit=0, valid=0, dirty=0, tag=0, dout=0.
- Reads: all outputs are purely combinational from addr and array state. Zero latency; they change in the same cycle addr changes.
- Writes: take effect at the rising edge. Outputs reflect the new contents from the next cycle; there is no write-through forwarding within the cycle.
- Command priority when several are asserted: invalid > store > edit. Only the highest-priority command executes.
- store:
  - writes one word and updates tag/valid/dirty for the whole line.
  - A 4-word refill issues 4 store cycles at offsets 0x0, 0x4, 0x8, 0xC with the same tag.
  - The line reports hit after the first store. Words not yet filled keep their old data.
- edit:
  - With hit=1 (evaluated before the edge): writes din to the word and sets dirty=1; tag and valid are unchanged.
  - With hit=0: no state change.
- invalid: clears valid and dirty of the indexed line. Data and tag are retained.
- With no command asserted, state holds.
- Replacement and write-back decisions are the controller's job. On a miss to a valid, dirty line, the cache must keep exposing the old tag, dirty and data until the controller overwrites them via store.

Test Plan:
1. Reset, then addr=0x0000_1234 -> hit=0, valid=0, dirty=0, tag=0, dout=0.
2. store din=0xA0..0xA3 at addr 0x1230/0x1234/0x1238/0x123C on consecutive cycles:
   - then addr=0x1238 -> hit=1, valid=1, dirty=0, tag=0x000004, dout=0xA2;
   - addr=0x1231 (byte offset) -> dout=0xA0.
3. edit din=0xDEAD_BEEF at 0x1234 (hit) -> next cycle dout=0xDEAD_BEEF, dirty=1, hit=1; word 0x1230 still 0xA0.
4. Conflict and miss edit:
   - addr=0x1630 (same index 0x23, tag 5) -> hit=0, valid=1, dirty=1, tag=0x000004;
   - edit at 0x1630 -> no change (0x1234 still 0xDEAD_BEEF, dirty=1).
5. Priority and invalidate:
   - store and edit together at 0x1630 din=0x55 -> tag=5, dirty=0, dout=0x55 (store wins);
   - invalid at 0x1630 -> valid=0, hit=0, dirty=0; dout still 0x55.
6. Reset mid-use: rst=1 for one cycle with edit=1 at a hit address -> all lines valid=0, dirty=0, data=0; the edit has no effect.
